// File: rtl/voice_pkg.sv
// voice_pkg: types and constants shared by the voice allocator and its
// per-voice occupancy trackers.
//   ctrl_state_e  : allocator control FSM (ACCEPT / LOAD / REST)
//   voice_state_e : per-voice occupancy (FREE / GUARDED / BUSY)
//   REST_NOTE     : note code that means "rest" rather than "play"
package voice_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_LOAD   = 2'd1,
    ST_REST   = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    V_FREE    = 2'd0,
    V_GUARDED = 2'd1,
    V_BUSY    = 2'd2
  } voice_state_e;

  localparam int REST_NOTE = 0;

endpackage

// File: rtl/voice_slot.sv
// voice_slot: occupancy tracker for one note player.
// A load moves the voice from FREE to GUARDED for GUARD cycles. During that
// window done is ignored, because the player's done_with_note level is still
// reporting the previous note. After the window the voice is BUSY, and it
// returns to FREE on done.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : one-cycle load strobe for this voice
//   done         : level from the player's done_with_note
//   is_free      : registered, 1 when the voice can take a new note
module voice_slot
  import voice_pkg::*;
#(
  parameter int GUARD = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic done,
  output logic is_free
);

  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  voice_state_e   state_q, state_d;
  logic [GW-1:0]  guard_q, guard_d;

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      V_FREE: begin
        if (load) begin
          if (GUARD == 0) begin
            state_d = V_BUSY;
          end else begin
            state_d = V_GUARDED;
            guard_d = GW'(GUARD);
          end
        end
      end
      V_GUARDED: begin
        // The last guarded cycle is the one in which the counter shows 1.
        if (guard_q <= GW'(1)) begin
          state_d = V_BUSY;
          guard_d = '0;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      V_BUSY: begin
        if (done) state_d = V_FREE;
      end
      default: begin
        state_d = V_FREE;
        guard_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= V_FREE;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
    end
  end

  assign is_free = (state_q == V_FREE);

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns incoming note requests to the lowest-index free
// note player, and implements rests as beat-counted stalls.
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   play                       : 1 = run, 0 = pause
//   beat                       : one-cycle beat pulse
//   req_valid/req_ready        : request handshake from the song reader
//   req_note, req_duration     : request payload (note 0 = rest)
//   voice_done[NUM_VOICES]     : done levels from the players
//   load_voice[NUM_VOICES]     : one-hot, one-cycle load strobe
//   load_note, load_duration   : payload for the strobed player
//   active_mask, active_count  : occupied voices and their popcount
//   all_idle                   : nothing playing, no rest, ready to accept
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int GUARD      = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              play,
  input  logic                              beat,
  input  logic                              req_valid,
  input  logic [NOTE_W-1:0]                 req_note,
  input  logic [DUR_W-1:0]                  req_duration,
  output logic                              req_ready,
  input  logic [NUM_VOICES-1:0]             voice_done,
  output logic [NUM_VOICES-1:0]             load_voice,
  output logic [NOTE_W-1:0]                 load_note,
  output logic [DUR_W-1:0]                  load_duration,
  output logic [NUM_VOICES-1:0]             active_mask,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count,
  output logic                              all_idle
);

  localparam int CNT_W = $clog2(NUM_VOICES + 1);

  ctrl_state_e             state_q, state_d;
  logic [NOTE_W-1:0]       note_q, note_d;
  logic [DUR_W-1:0]        dur_q, dur_d;
  logic [NUM_VOICES-1:0]   sel_q, sel_d;
  logic [DUR_W-1:0]        rest_q, rest_d;

  logic [NUM_VOICES-1:0]   free_vec;
  logic [NUM_VOICES-1:0]   lowest_free;
  logic                    any_free;
  logic                    is_rest;

  // Per-voice occupancy trackers.
  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
    voice_slot #(.GUARD(GUARD)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load_voice[gi]),
      .done    (voice_done[gi]),
      .is_free (free_vec[gi])
    );
  end

  // Lowest-index free voice as a one-hot vector.
  always_comb begin
    logic found;
    lowest_free = '0;
    found       = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (free_vec[i] && !found) begin
        lowest_free[i] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign any_free = |free_vec;
  assign is_rest  = (req_note == NOTE_W'(REST_NOTE));

  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    dur_d      = dur_q;
    sel_d      = sel_q;
    rest_d     = rest_q;
    req_ready  = 1'b0;
    load_voice = '0;
    case (state_q)
      ST_ACCEPT: begin
        // Gated with reset_n so that no request is taken while reset is held.
        req_ready = reset_n & play & (is_rest | any_free);
        if (req_valid && req_ready) begin
          if (!is_rest) begin
            note_d  = req_note;
            dur_d   = req_duration;
            sel_d   = lowest_free;
            state_d = ST_LOAD;
          end else if (req_duration != '0) begin
            rest_d  = req_duration;
            state_d = ST_REST;
          end
        end
      end
      ST_LOAD: begin
        // Completes even while paused.
        load_voice = sel_q;
        state_d    = ST_ACCEPT;
      end
      ST_REST: begin
        if (rest_q == '0) begin
          state_d = ST_ACCEPT;
        end else if (beat && play) begin
          rest_d = rest_q - DUR_W'(1);
          if (rest_q == DUR_W'(1)) state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACCEPT;
      note_q  <= '0;
      dur_q   <= '0;
      sel_q   <= '0;
      rest_q  <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      sel_q   <= sel_d;
      rest_q  <= rest_d;
    end
  end

  // Status outputs come from registered state only.
  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      active_count = active_count + CNT_W'(active_mask[i]);
    end
  end

  assign active_mask   = ~free_vec;
  assign all_idle      = (state_q == ST_ACCEPT) && (&free_vec) && (rest_q == '0);
  assign load_note     = note_q;
  assign load_duration = dur_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;
  localparam int GD = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          play;
  logic          beat;
  logic          req_valid;
  logic [NW-1:0] req_note;
  logic [DW-1:0] req_duration;
  logic          req_ready;
  logic [NV-1:0] voice_done;
  logic [NV-1:0] load_voice;
  logic [NW-1:0] load_note;
  logic [DW-1:0] load_duration;
  logic [NV-1:0] active_mask;
  logic [1:0]    active_count;
  logic          all_idle;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .GUARD(GD)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .play          (play),
    .beat          (beat),
    .req_valid     (req_valid),
    .req_note      (req_note),
    .req_duration  (req_duration),
    .req_ready     (req_ready),
    .voice_done    (voice_done),
    .load_voice    (load_voice),
    .load_note     (load_note),
    .load_duration (load_duration),
    .active_mask   (active_mask),
    .active_count  (active_count),
    .all_idle      (all_idle)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: which voices hold a note and in which cycle each was
  // strobed; a pending strobe; beats left in the current rest; last payload.
  bit            occ[NV];
  int            load_cyc[NV];
  int            pend;
  int            rest_left;
  int            m_note;
  int            m_dur;

  bit            play_r;
  int            beat_mode;   // 0 none, 1 every 8 cycles, 2 random
  logic [NV-1:0] done_r;
  bit            last_accept;
  bit            last_beat;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      occ[i]      = 1'b0;
      load_cyc[i] = 0;
    end
    pend      = -1;
    rest_left = 0;
    m_note    = 0;
    m_dur     = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, check all outputs against
  // the model, then advance the model to the next cycle.
  task automatic tick(input bit v, input int n, input int d);
    int            lowest;
    bit            exp_ready;
    bit            b;
    logic [NV-1:0] em;
    int            ec;
    @(negedge clk);
    if (beat_mode == 1)      b = (cyc % 8 == 0);
    else if (beat_mode == 2) b = ($urandom_range(0, 3) == 0);
    else                     b = 1'b0;
    req_valid    = v;
    req_note     = NW'(n);
    req_duration = DW'(d);
    play         = play_r;
    beat         = b;
    voice_done   = done_r;
    #1;
    lowest = -1;
    for (int i = NV - 1; i >= 0; i--) if (!occ[i]) lowest = i;
    em = '0;
    ec = 0;
    for (int i = 0; i < NV; i++) if (occ[i]) begin em[i] = 1'b1; ec++; end
    exp_ready = play_r && (pend < 0) && (rest_left == 0) && (n == 0 || lowest >= 0);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("load_voice", 32'(load_voice), (pend >= 0) ? (32'd1 << pend) : 32'd0);
    chk("load_note", 32'(load_note), 32'(m_note));
    chk("load_duration", 32'(load_duration), 32'(m_dur));
    chk("active_mask", 32'(active_mask), 32'(em));
    chk("active_count", 32'(active_count), 32'(ec));
    chk("all_idle", 32'(all_idle), 32'(ec == 0 && pend < 0 && rest_left == 0));
    last_accept = v && exp_ready;
    last_beat   = b;
    // A voice is BUSY from GD+1 cycles after its strobe; only then does done free it.
    for (int i = 0; i < NV; i++)
      if (occ[i] && done_r[i] && cyc >= load_cyc[i] + 1 + GD) occ[i] = 1'b0;
    if (pend >= 0) begin
      occ[pend]      = 1'b1;
      load_cyc[pend] = cyc;
      pend           = -1;
    end else if (rest_left > 0) begin
      if (b && play_r) rest_left--;
    end else if (last_accept) begin
      if (n != 0) begin
        pend   = lowest;
        m_note = n;
        m_dur  = d;
      end else if (d != 0) begin
        rest_left = d;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 1'b1;
    req_note  = '0;
    play      = 1'b1;
    beat      = 1'b0;
    voice_done = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_load_voice", 32'(load_voice), 32'd0);
    chk("rst_load_note", 32'(load_note), 32'd0);
    chk("rst_load_duration", 32'(load_duration), 32'd0);
    chk("rst_active_mask", 32'(active_mask), 32'd0);
    chk("rst_active_count", 32'(active_count), 32'd0);
    chk("rst_all_idle", 32'(all_idle), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    model_reset();
    play_r    = 1'b1;
    done_r    = '0;
    beat_mode = 0;
  endtask

  initial begin
    int k;
    int beats;
    int occ_cycles;
    int n;
    reset_n = 1'b0;
    play = 1'b0; beat = 1'b0; req_valid = 1'b0;
    req_note = '0; req_duration = '0; voice_done = '0;
    model_reset();
    play_r = 1'b1; done_r = '0; beat_mode = 0;

    // Single note: strobe next cycle, occupancy two cycles after accept.
    do_reset();
    tick(1, 12, 4);
    chk("t1_ready", 32'(req_ready), 32'd1);
    tick(0, 0, 0);
    chk("t1_load_voice", 32'(load_voice), 32'b001);
    chk("t1_load_note", 32'(load_note), 32'd12);
    chk("t1_load_duration", 32'(load_duration), 32'd4);
    tick(0, 0, 0);
    chk("t1_active_count", 32'(active_count), 32'd1);

    // Three back-to-back notes fill the voices; a fourth waits for a free.
    do_reset();
    tick(1, 10, 1);
    tick(1, 20, 2);
    chk("t2_load_v0", 32'(load_voice), 32'b001);
    chk("t2_ready_in_load", 32'(req_ready), 32'd0);
    tick(1, 20, 2);
    tick(1, 30, 3);
    chk("t2_load_v1", 32'(load_voice), 32'b010);
    tick(1, 30, 3);
    tick(1, 40, 5);
    chk("t2_load_v2", 32'(load_voice), 32'b100);
    for (int i = 0; i < 5; i++) begin
      tick(1, 40, 5);
      chk("t2_held", 32'(req_ready), 32'd0);
    end
    done_r = 3'b010;
    tick(1, 40, 5);
    chk("t2_free_same_cycle", 32'(req_ready), 32'd0);
    done_r = 3'b000;
    tick(1, 40, 5);
    chk("t2_ready_after_free", 32'(req_ready), 32'd1);
    tick(0, 0, 0);
    chk("t2_reload_v1", 32'(load_voice), 32'b010);
    chk("t2_reload_note", 32'(load_note), 32'd40);

    // done held high through the load: guard keeps the voice occupied.
    do_reset();
    done_r = 3'b001;
    tick(1, 7, 3);
    tick(0, 0, 0);
    occ_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0);
      if (active_mask[0] === 1'b1) occ_cycles++;
    end
    chk("t3_guard_cycles", 32'(occ_cycles), 32'(GD + 1));
    done_r = 3'b000;

    // Rest of 3 beats, then a zero-length rest.
    do_reset();
    beat_mode = 1;
    tick(1, 0, 3);
    chk("t4_rest_ready", 32'(req_ready), 32'd1);
    beats = 0;
    k = 0;
    do begin
      tick(0, 0, 0);
      k++;
      if (req_ready !== 1'b1) beats += int'(last_beat);
    end while (req_ready !== 1'b1 && k < 100);
    chk("t4_rest_done", 32'(req_ready), 32'd1);
    chk("t4_rest_beats", 32'(beats), 32'd3);
    beat_mode = 0;
    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("t4_zero_rest_ready", 32'(req_ready), 32'd1);
    chk("t4_zero_rest_idle", 32'(all_idle), 32'd1);

    // Pause during a rest after one beat: two more beats needed afterwards.
    do_reset();
    beat_mode = 1;
    tick(1, 0, 3);
    beats = 0;
    k = 0;
    do begin
      tick(0, 0, 0);
      k++;
      beats += int'(last_beat);
    end while (beats < 1 && k < 100);
    play_r = 1'b0;
    for (int i = 0; i < 20; i++) tick(0, 0, 0);
    chk("t5_paused_ready", 32'(req_ready), 32'd0);
    play_r = 1'b1;
    beats = 0;
    k = 0;
    do begin
      tick(0, 0, 0);
      k++;
      if (req_ready !== 1'b1) beats += int'(last_beat);
    end while (req_ready !== 1'b1 && k < 100);
    chk("t5_resume_done", 32'(req_ready), 32'd1);
    chk("t5_resume_beats", 32'(beats), 32'd2);
    beat_mode = 0;

    // Reset during LOAD clears everything at once.
    do_reset();
    tick(1, 33, 2);
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("t6_load_voice", 32'(load_voice), 32'd0);
    chk("t6_active_mask", 32'(active_mask), 32'd0);
    chk("t6_all_idle", 32'(all_idle), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    tick(1, 5, 1);
    tick(0, 0, 0);
    chk("t6_reload_v0", 32'(load_voice), 32'b001);

    // Randomized traffic against the model.
    do_reset();
    beat_mode = 2;
    for (int i = 0; i < 800; i++) begin
      play_r = ($urandom_range(0, 9) != 0);
      done_r = NV'($urandom);
      n = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 63));
      tick(bit'($urandom_range(0, 1)), n, int'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Sequencing controller for the three-voice chord datapath. It accepts note requests from the song reader over a valid/ready handshake and assigns each note to the lowest-index free note player by pulsing that player's load strobe. It tracks per-voice occupancy and implements rests (note 0) as beat-counted stalls. It reports the active-voice count so the mixer can pick its gain shift without re-deriving it.

## Interface
- NUM_VOICES, 3, number of note players driven (2..7)
- NOTE_W, 6, note code width
- DUR_W, 6, duration width in beats
- GUARD, 2, cycles after a load during which voice_done for that voice is ignored
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- play  in  1  1 = run; 0 = pause (no accepts, no loads, rest counter frozen)
- beat  in  1  one-cycle beat pulse
- req_valid  in  1  request present
- req_note  in  NOTE_W  note code; 0 = rest
- req_duration  in  DUR_W  note length or rest length in beats
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- voice_done  in  NUM_VOICES  level from each player's done_with_note
- load_voice  out  NUM_VOICES  one-hot, one-cycle load strobe to players
- load_note  out  NOTE_W  note for the strobed player
- load_duration  out  DUR_W  duration for the strobed player
- active_mask  out  NUM_VOICES  1 = voice occupied
- active_count  out  $clog2(NUM_VOICES+1)  popcount of active_mask
- all_idle  out  1  no voice active, no rest pending, FSM in ACCEPT

## Operation
- Per-voice state: FREE, GUARDED (count GUARD..1), BUSY. Load moves FREE -> GUARDED(GUARD). GUARDED decrements each cycle and goes to BUSY at 1. BUSY -> FREE when voice_done=1. voice_done is ignored in FREE and GUARDED.
- Control FSM: ACCEPT, LOAD, REST.
- ACCEPT: req_ready = play & (req_note==0 | any FREE voice). This is combinational on req_note and registered voice state.
- Accept with req_note!=0: latch note/duration, select lowest-index FREE voice, go to LOAD.
- Accept with req_note==0: if req_duration==0, stay in ACCEPT (request consumed, no effect). Otherwise load the rest counter with req_duration and go to REST.
- LOAD (one cycle): load_voice asserted on the selected bit, load_note/load_duration valid, voice enters GUARDED. Return to ACCEPT. req_ready=0.
- REST: req_ready=0. Each beat while play=1 decrements the counter. When the counter reaches 0, return to ACCEPT.
- play=0: req_ready=0. An in-flight LOAD still completes. Beats are not counted. Voice state still follows voice_done.
- No free voice and note!=0: req_ready stays 0 until a voice frees. There is no voice stealing.
- load_note/load_duration hold their last value outside LOAD. Players qualify them only with load_voice.

## Timing
- Reset values: req_ready 0 during reset, load_voice 0, load_note 0, load_duration 0, active_mask 0, active_count 0, all_idle 1. FSM goes to ACCEPT, voices to FREE, rest counter to 0.
- Accept in cycle t: load_voice pulses in t+1, and active_mask bit sets in t+2. Maximum throughput is one note per 2 cycles.
- A voice freed by voice_done in cycle t is visible to req_ready in t+1. A free and a request in the same cycle do not combine.
- Rest of D beats accepted in t: counting starts at t+1, and req_ready can return the cycle after the D-th counted beat.
- active_count and all_idle are derived from registered state only, with no input-to-output path.
- Asserting reset_n low mid-LOAD or mid-REST clears everything immediately. No load strobe is emitted after reset.

## Structure
- Shared package voice_pkg: FSM state enum (ACCEPT, LOAD, REST), voice state encoding, REST_NOTE = 0.
- One sub-module, voice_slot (per-voice FREE/GUARDED/BUSY tracker with guard counter), instantiated NUM_VOICES times via generate. The allocator holds the FSM, the lowest-free priority encoder, the rest counter and the popcount.

## Test plan
- Reset, then req note 12 dur 4 with play=1 -> req_ready=1, load_voice=001 the next cycle, load_note=12, load_duration=4, and active_count=1 two cycles after accept.
- Three back-to-back notes 10/20/30 -> load_voice 001, 010, 100 on alternate cycles. A fourth request is held with req_ready=0 until voice_done[1] rises. It then loads into voice 1 (010).
- voice_done held 1 through the load -> voice stays occupied for GUARD cycles and frees only on voice_done=1 after entering BUSY.
- Rest, note 0 dur 3, with beats every 8 cycles -> req_ready=0 until the 3rd beat after accept. Dur 0 rest -> consumed with no stall.
- play dropped during REST after 1 beat -> beats ignored. After play returns, 2 more beats are required.
- reset_n asserted low during LOAD -> load_voice=0 immediately, active_mask=0, all_idle=1. The next request after release loads into voice 0.
